// File: rtl/kronos_dbus_if.sv
// kronos_dbus_if: LSU, SRAM and peripheral bus bundle for kronos_dbus.
// master = the router, slave = the LSU/SRAM/peripheral side.
interface kronos_dbus_if #(
  parameter int AW = 14
);
  logic [31:0]   data_addr;
  logic [31:0]   data_wr_data;
  logic [3:0]    data_wr_mask;
  logic          data_wr_en;
  logic          data_req;
  logic [31:0]   data_rd_data;
  logic          data_ack;
  logic          bus_err;

  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [3:0]    sram_wmask;
  logic [31:0]   sram_rdata;

  logic          per_valid;
  logic [31:0]   per_addr;
  logic [31:0]   per_wdata;
  logic [3:0]    per_wmask;
  logic          per_we;
  logic          per_ready;
  logic [31:0]   per_rdata;

  modport master (
    input  data_addr, data_wr_data, data_wr_mask,
    input  data_wr_en, data_req,
    output data_rd_data, data_ack, bus_err,
    output sram_en, sram_we, sram_addr,
    output sram_wdata, sram_wmask,
    input  sram_rdata,
    output per_valid, per_addr, per_wdata,
    output per_wmask, per_we,
    input  per_ready, per_rdata
  );

  modport slave (
    output data_addr, data_wr_data, data_wr_mask,
    output data_wr_en, data_req,
    input  data_rd_data, data_ack, bus_err,
    input  sram_en, sram_we, sram_addr,
    input  sram_wdata, sram_wmask,
    output sram_rdata,
    input  per_valid, per_addr, per_wdata,
    input  per_wmask, per_we,
    output per_ready, per_rdata
  );
endinterface

// File: rtl/kronos_dbus.sv
// kronos_dbus: LSU data bus router, TCM SRAM vs peripheral port.
// Define KRONOS_DBUS_TIMEOUT_EN to build the peripheral wait timeout.
module kronos_dbus #(
  parameter logic [31:0] SRAM_BASE      = 32'h0000_0000,
  parameter logic [31:0] SRAM_SIZE      = 32'h0001_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rstz,
  kronos_dbus_if.master    bus
);

  localparam int AW = $clog2(SRAM_SIZE) - 2;
  localparam logic [31:0] HI_MASK = ~(SRAM_SIZE - 32'd1);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255
      || SRAM_SIZE < 32'd8) begin : g_bad_cfg
    $error("kronos_dbus: bad parameter value");
  end

  typedef enum logic [1:0] {
    IDLE, SRAM, PER, RESP
  } state_e;

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        pv_q, pv_d;
  logic [31:0] pa_q, pa_d;
  logic [31:0] pwd_q, pwd_d;
  logic [3:0]  pwm_q, pwm_d;
  logic        pwe_q, pwe_d;
  logic        sram_en;
  logic        hit;

`ifdef KRONOS_DBUS_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  assign hit = (bus.data_addr & HI_MASK) == SRAM_BASE;

  // Next-state and registered outputs of the access FSM.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    we_d    = we_q;
    pv_d    = pv_q;
    pa_d    = pa_q;
    pwd_d   = pwd_q;
    pwm_d   = pwm_q;
    pwe_d   = pwe_q;
    sram_en = 1'b0;
`ifdef KRONOS_DBUS_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.data_req) begin
          if (hit) begin
            sram_en = 1'b1;
            we_d    = bus.data_wr_en;
            state_d = SRAM;
          end else begin
            pv_d    = 1'b1;
            pa_d    = {bus.data_addr[31:2], 2'b00};
            pwd_d   = bus.data_wr_data;
            pwm_d   = bus.data_wr_mask;
            pwe_d   = bus.data_wr_en;
`ifdef KRONOS_DBUS_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
            state_d = PER;
          end
        end
      end
      SRAM: begin
        rdata_d = we_q ? 32'd0 : bus.sram_rdata;
        ack_d   = 1'b1;
        state_d = RESP;
      end
      PER: begin
        if (bus.per_ready) begin
          rdata_d = pwe_q ? 32'd0 : bus.per_rdata;
          ack_d   = 1'b1;
          pv_d    = 1'b0;
          state_d = RESP;
        end
`ifdef KRONOS_DBUS_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'd0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          pv_d    = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      pv_q    <= 1'b0;
      pa_q    <= 32'd0;
      pwd_q   <= 32'd0;
      pwm_q   <= 4'd0;
      pwe_q   <= 1'b0;
`ifdef KRONOS_DBUS_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      pv_q    <= pv_d;
      pa_q    <= pa_d;
      pwd_q   <= pwd_d;
      pwm_q   <= pwm_d;
      pwe_q   <= pwe_d;
`ifdef KRONOS_DBUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.data_ack     = ack_q;
  assign bus.data_rd_data = rdata_q;
`ifdef KRONOS_DBUS_TIMEOUT_EN
  assign bus.bus_err      = err_q;
`else
  assign bus.bus_err      = 1'b0;
`endif

  assign bus.sram_en    = sram_en;
  assign bus.sram_we    = bus.data_wr_en;
  assign bus.sram_addr  = bus.data_addr[AW+1:2];
  assign bus.sram_wdata = bus.data_wr_data;
  assign bus.sram_wmask = bus.data_wr_mask;

  assign bus.per_valid = pv_q;
  assign bus.per_addr  = pa_q;
  assign bus.per_wdata = pwd_q;
  assign bus.per_wmask = pwm_q;
  assign bus.per_we    = pwe_q;

endmodule

// File: doc/kronos_dbus.md
# kronos_dbus

Data bus router sitting directly downstream of the load/store unit's memory interface. It accepts word-aligned LSU requests (`data_req`/`data_ack`), decodes the address, and serves them either from a tightly-coupled synchronous SRAM or from an external peripheral port with a valid/ready handshake. It returns one registered acknowledge pulse per access, with read data valid in that cycle. Optional timeout protection covers the peripheral port.

## Interface
- `SRAM_BASE`, default 32'h0000_0000: SRAM base byte address; must be aligned to `SRAM_SIZE`.
- `SRAM_SIZE`, default 32'h0001_0000: SRAM size in bytes; power of two, ≥ 8.
- `TIMEOUT_CYCLES`, default 255: peripheral wait limit in cycles; range 1..255. Used only when the timeout feature is compiled in.
- `clk` in 1: clock.
- `rstz` in 1: reset, asynchronous, active-low.
- `data_addr` in 32: LSU word address; bits [1:0] are ignored.
- `data_wr_data` in 32: write data.
- `data_wr_mask` in 4: byte write enables.
- `data_wr_en` in 1: 1 = write, 0 = read.
- `data_req` in 1: request; held high by the LSU until acked.
- `data_rd_data` out 32: read data; registered.
- `data_ack` out 1: single-cycle completion pulse; registered.
- `bus_err` out 1: pulses with `data_ack` on a peripheral timeout.
- `sram_en` out 1: SRAM access strobe; combinational.
- `sram_we` out 1: SRAM write.
- `sram_addr` out AW: word index, where AW = log2(`SRAM_SIZE`) − 2.
- `sram_wdata` out 32: SRAM write data.
- `sram_wmask` out 4: SRAM byte mask.
- `sram_rdata` in 32: SRAM read data, valid the cycle after `sram_en`.
- `per_valid` out 1: peripheral request; registered.
- `per_addr` out 32: peripheral word address; registered.
- `per_wdata` out 32: peripheral write data; registered.
- `per_wmask` out 4: peripheral byte mask; registered.
- `per_we` out 1: peripheral write; registered.
- `per_ready` in 1: peripheral completion.
- `per_rdata` in 32: peripheral read data, sampled when `per_ready` is high.

## Operation
- States: IDLE, SRAM, PER, RESP.
- Decode: SRAM hit when `(data_addr & ~(SRAM_SIZE-1)) == SRAM_BASE`; otherwise the access goes to the peripheral port.
- In IDLE with `data_req` high:
  - On a hit, `sram_en` = 1 in that cycle, with `sram_we`/`sram_wdata`/`sram_wmask` passed through from the LSU inputs. `sram_addr` = `data_addr[AW+1:2]`. Next state is SRAM.
  - On a miss, register the `per_*` signals from the LSU inputs and set `per_valid` to 1. Next state is PER.
- SRAM state:
  - `data_rd_data` <= `sram_rdata` for a read, or 0 for a write.
  - `data_ack` <= 1.
  - Next state is RESP.
- PER state:
  - When `per_ready` is high: `data_rd_data` <= `per_rdata` for a read, or 0 for a write. Then `data_ack` <= 1, `per_valid` <= 0, and next state is RESP.
  - Otherwise, hold all `per_*` signals stable.
- RESP state: `data_ack` = 1 in this cycle and <= 0 next. Next state is IDLE. `data_req` is ignored in RESP because the LSU is still holding its previous request.
- `sram_en` = 0 outside of IDLE & `data_req` & hit.
- Back-to-back requests: the LSU updates `data_addr` on the ack edge and keeps `data_req` high for a boundary-cross second access. IDLE accepts that request in the very next cycle; no request is lost or duplicated.
- `data_req` falling while in SRAM or PER state is illegal and is ignored: the transaction completes normally.

## Timing
- Reset values: state IDLE; `data_ack` 0; `data_rd_data` 0; `bus_err` 0; `per_valid` 0; `per_addr`/`per_wdata` 0; `per_wmask` 0; `per_we` 0.
- Asynchronous reset mid-transaction returns to IDLE immediately and drops `per_valid` without completing.
- SRAM latency: request seen in cycle 0, `data_ack` high in cycle 2. Each SRAM access occupies 3 cycles.
- Peripheral: `per_valid` rises in cycle 1. If `per_ready` is high in cycle N, `data_ack` is high in cycle N+1.
- `data_ack` never stays high for more than one consecutive cycle.
- At most one outstanding transaction at any time.

## Configuration
- `KRONOS_DBUS_TIMEOUT_EN` defined:
  - An 8-bit wait counter is cleared on entry to PER and increments on each PER cycle with `per_ready` low.
  - If the counter equals `TIMEOUT_CYCLES`−1 and `per_ready` is low, the access times out: `per_valid` <= 0, `data_rd_data` <= 0, `data_ack` <= 1, `bus_err` <= 1, and next state is RESP.
  - `bus_err` is high for exactly one cycle, aligned with `data_ack`.
  - `per_valid` is therefore high for at most `TIMEOUT_CYCLES` cycles.
  - If `per_ready` is high in the timeout cycle, `per_ready` wins and no error is flagged.
- `KRONOS_DBUS_TIMEOUT_EN` undefined: no counter is built, PER waits indefinitely, and `bus_err` is tied to 0.

## Test plan
- SRAM read: preload word 0x10 = 0xDEADBEEF, then request a read at 0x10 → `sram_en` high in cycle 0 with `sram_addr` = 4; `data_ack` high in cycle 2 with `data_rd_data` = 0xDEADBEEF.
- SRAM write: write 0x11223344 to 0x20 with mask 4'b0110 → SRAM receives `we` = 1 and mask 0110; ack in cycle 2 with `data_rd_data` = 0. A readback shows only bytes 1–2 changed.
- Boundary cross: read 0x0C, then keep `data_req` high after the ack with the address advanced to 0x10 → two acks exactly 3 cycles apart, each carrying its own word; `sram_en` pulses exactly twice.
- Peripheral: read 0x8000_0004 with `per_ready` asserted 5 cycles after `per_valid` with `per_rdata` = 0xCAFE0001 → ack one cycle later with 0xCAFE0001; `per_valid` low after the ack.
- Timeout (macro on, `TIMEOUT_CYCLES` = 4): read a peripheral address that never readies → `per_valid` high for 4 cycles; `data_ack` and `bus_err` high together for one cycle; `data_rd_data` = 0. With `per_ready` in exactly the 4th cycle → normal ack with `bus_err` = 0.
- Reset mid-PER: drop `rstz` while `per_valid` is high → `per_valid` and `data_ack` read 0 immediately; after release, a fresh SRAM read completes normally.
